// File: rtl/ws2812_rz_decode_pkg.sv
// Shared constants for the WS2812 RZ decoder: FSM state codes, default thresholds and the
// encoder's nominal symbol timing (cycles at 50 MHz).
package ws2812_pkg;

  typedef logic [1:0] rz_state_t;

  localparam rz_state_t StSync = 2'd0;
  localparam rz_state_t StIdle = 2'd1;
  localparam rz_state_t StHigh = 2'd2;
  localparam rz_state_t StLow  = 2'd3;

  localparam int unsigned OneMinDflt   = 32;
  localparam int unsigned MinHighDflt  = 4;
  localparam int unsigned HighMaxDflt  = 56;
  localparam int unsigned ResetLowDflt = 2500;

  // Encoder side: high widths for 0/1 and the full bit period.
  localparam int unsigned EncT0High    = 21;
  localparam int unsigned EncT1High    = 43;
  localparam int unsigned EncBitPeriod = 63;

  localparam int unsigned WordBits = 24;
  localparam int unsigned CntW     = 12;

endpackage

// File: rtl/ws2812_rz_decode_if.sv
// Decoder line/word bundle. master drives the RZ line and observes results; slave is the decoder.
interface ws2812_rz_decode_if;
  logic        RZ_data;
  logic [23:0] RGB;
  logic        rx_valid;
  logic        frame_end;
  logic        rx_err;
  logic        fwd_data;

  modport master (
    output RZ_data,
    input  RGB, rx_valid, frame_end, rx_err, fwd_data
  );

  modport slave (
    input  RZ_data,
    output RGB, rx_valid, frame_end, rx_err, fwd_data
  );
endinterface

// File: rtl/ws2812_rz_decode_rz_sync_edge.sv
// Two-flop synchronizer for the asynchronous RZ line plus one history flop for edge detection.
module rz_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_data,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_data;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/ws2812_rz_decode.sv
// WS2812 RZ stream decoder: classifies symbols by high width, packs 24-bit GRB words MSB-first.
// Define WS2812_RZ_DECODE_FWD_EN for pixel mode (first word kept, rest forwarded on fwd_data).
module ws2812_rz_decode
  import ws2812_pkg::*;
#(
  parameter int unsigned ONE_MIN   = OneMinDflt,
  parameter int unsigned MIN_HIGH  = MinHighDflt,
  parameter int unsigned HIGH_MAX  = HighMaxDflt,
  parameter int unsigned RESET_LOW = ResetLowDflt
) (
  input logic               clk,
  input logic               rst_n,
  ws2812_rz_decode_if.slave bus
);

  localparam logic [CntW-1:0] OneMin   = CntW'(ONE_MIN);
  localparam logic [CntW-1:0] MinHigh  = CntW'(MIN_HIGH);
  localparam logic [CntW-1:0] HighMax  = CntW'(HIGH_MAX);
  localparam logic [CntW-1:0] ResetLow = CntW'(RESET_LOW);

  logic w_level, w_rise, w_fall;

  rz_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (bus.RZ_data),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  rz_state_t       r_state, w_state_d;
  logic [CntW-1:0] r_high_cnt, w_high_cnt_d, w_high_inc;
  logic [CntW-1:0] r_low_cnt, w_low_cnt_d, w_low_inc;
  logic [4:0]      r_bit_cnt, w_bit_cnt_d;
  logic [22:0]     r_shreg, w_shreg_d;
  logic [23:0]     r_rgb, w_rgb_d;
  logic            r_rx_valid, w_rx_valid_d;
  logic            r_frame_end, w_frame_end_d;
  logic            r_rx_err, w_rx_err_d;
  logic            r_fwd;
  logic            w_bit, w_decode_en, w_word_set, w_word_clr;

  assign w_high_inc = r_high_cnt + 1'b1;
  assign w_low_inc  = (r_low_cnt == ResetLow) ? r_low_cnt : r_low_cnt + 1'b1;
  assign w_bit      = (r_high_cnt >= OneMin);

  always_comb begin
    w_state_d     = r_state;
    w_high_cnt_d  = r_high_cnt;
    w_low_cnt_d   = r_low_cnt;
    w_bit_cnt_d   = r_bit_cnt;
    w_shreg_d     = r_shreg;
    w_rgb_d       = r_rgb;
    w_rx_valid_d  = 1'b0;
    w_frame_end_d = 1'b0;
    w_rx_err_d    = 1'b0;
    w_word_set    = 1'b0;
    w_word_clr    = 1'b0;

    unique case (r_state)
      // Wait for a full reset gap so decoding never starts mid-stream.
      StSync: begin
        if (w_level) begin
          w_low_cnt_d = '0;
        end else if (r_low_cnt == ResetLow) begin
          w_low_cnt_d = '0;
          w_state_d   = StIdle;
        end else begin
          w_low_cnt_d = w_low_inc;
        end
      end
      StIdle: begin
        if (w_rise) begin
          w_high_cnt_d = '0;
          w_state_d    = StHigh;
        end
      end
      StHigh: begin
        if (w_fall) begin
          w_low_cnt_d = '0;
          w_state_d   = StLow;
          if (r_high_cnt < MinHigh) begin
            w_rx_err_d = 1'b1;
          end else if (w_decode_en) begin
            if (r_bit_cnt == 5'd23) begin
              w_rgb_d      = {r_shreg, w_bit};
              w_rx_valid_d = 1'b1;
              w_bit_cnt_d  = '0;
              w_word_set   = 1'b1;
            end else begin
              w_shreg_d   = {r_shreg[21:0], w_bit};
              w_bit_cnt_d = r_bit_cnt + 1'b1;
            end
          end
        end else if (w_high_inc == HighMax) begin
          w_high_cnt_d = w_high_inc;
          w_rx_err_d   = 1'b1;
          w_bit_cnt_d  = '0;
          w_low_cnt_d  = '0;
          w_word_clr   = 1'b1;
          w_state_d    = StSync;
        end else begin
          w_high_cnt_d = w_high_inc;
        end
      end
      StLow: begin
        if (w_rise) begin
          w_high_cnt_d = '0;
          w_state_d    = StHigh;
        end else if (r_low_cnt == ResetLow) begin
          w_frame_end_d = 1'b1;
          w_rx_err_d    = (r_bit_cnt != '0);
          w_bit_cnt_d   = '0;
          w_word_clr    = 1'b1;
          w_state_d     = StIdle;
        end else begin
          w_low_cnt_d = w_low_inc;
        end
      end
      default: w_state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StSync;
      r_high_cnt  <= '0;
      r_low_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_rgb       <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_end <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_high_cnt  <= w_high_cnt_d;
      r_low_cnt   <= w_low_cnt_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shreg     <= w_shreg_d;
      r_rgb       <= w_rgb_d;
      r_rx_valid  <= w_rx_valid_d;
      r_frame_end <= w_frame_end_d;
      r_rx_err    <= w_rx_err_d;
    end
  end

`ifdef WS2812_RZ_DECODE_FWD_EN
  // Set once the first word of the frame is taken; doubles as the forwarding enable.
  logic r_word_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_taken <= 1'b0;
      r_fwd        <= 1'b0;
    end else begin
      if (w_word_clr) begin
        r_word_taken <= 1'b0;
      end else if (w_word_set) begin
        r_word_taken <= 1'b1;
      end
      r_fwd <= r_word_taken ? w_level : 1'b0;
    end
  end

  assign w_decode_en = ~r_word_taken;
`else
  logic w_unused_word;

  assign w_unused_word = w_word_set ^ w_word_clr;
  assign w_decode_en   = 1'b1;
  assign r_fwd         = 1'b0;
`endif

  assign bus.RGB       = r_rgb;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_end = r_frame_end;
  assign bus.rx_err    = r_rx_err;
  assign bus.fwd_data  = r_fwd;

endmodule

// File: tb/tb_ws2812_rz_decode.sv
// Self-checking bench for ws2812_rz_decode: table of frames plus stuck-high and mid-word reset.
module tb_ws2812_rz_decode;
  import ws2812_pkg::*;

  localparam int unsigned ResetLow = ResetLowDflt;
  localparam int unsigned Gap      = ResetLow + 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  ws2812_rz_decode_if bus ();

  ws2812_rz_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [47:0] data;
    int          nbits;
    int          glitch_at;
    int          exp_words_mon;
    int          exp_words_fwd;
    int          exp_err;
    int          exp_fe;
    int          exp_fe_err;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0, n_fe = 0, n_err = 0, n_fe_err = 0;
  int last_valid_cyc = 0, fe_cyc = 0, err_cyc = 0;
  int fwd_bad = 0, fwd_ones = 0, fwd_high = 0;
  bit fwd_win = 1'b0;
  logic [2:0] lh = '0;
  logic [23:0] exp_q[$];
  logic [23:0] model_rgb = '0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_valid_unexpected: got RGB %0h, expected no word", bus.RGB);
        end else begin
          chk("rgb_word", 48'(bus.RGB), 48'(exp_q.pop_front()));
        end
      end
      if (bus.frame_end) begin
        n_fe++;
        fe_cyc = cyc;
      end
      if (bus.rx_err) begin
        n_err++;
        err_cyc = cyc;
        if (bus.frame_end) n_fe_err++;
      end
      if (fwd_win && (bus.fwd_data !== lh[2])) fwd_bad++;
      if (fwd_win && bus.fwd_data) fwd_ones++;
      if (bus.fwd_data) fwd_high++;
    end
    lh = {lh[1:0], bus.RZ_data};
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic hold(input logic v, input int n);
    bus.RZ_data = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? EncT1High : EncT0High);
    hold(1'b0, b ? EncBitPeriod - EncT1High : EncBitPeriod - EncT0High);
  endtask

  task automatic send_bits(input logic [47:0] data, input int first, input int n);
    for (int i = first; i < first + n; i++) send_bit(data[47-i]);
  endtask

  vec_t vecs[6];
  int   v_valid, v_err, v_fe, v_fe_err, exp_w, n0, fwd_ones0;

  initial begin
    vecs[0] = '{48'hA5C33C_000000, 24, -1, 1, 1, 0, 1, 0};
    vecs[1] = '{48'h123456_ABCDEF, 48, -1, 2, 1, 0, 1, 0};
    vecs[2] = '{48'hA5C33C_000000, 24,  5, 1, 1, 1, 1, 0};
    vecs[3] = '{48'hB30000_000000, 10, -1, 0, 0, 1, 1, 1};
    vecs[4] = '{48'hFFFFFF_000000, 24, -1, 1, 1, 0, 1, 0};
    vecs[5] = '{48'h000000_000000, 24, -1, 1, 1, 0, 1, 0};

    bus.RZ_data = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_rgb", 48'(bus.RGB), 48'h0);
    chk("reset_rx_valid", 48'(bus.rx_valid), 48'h0);
    chk("reset_frame_end", 48'(bus.frame_end), 48'h0);
    chk("reset_rx_err", 48'(bus.rx_err), 48'h0);
    chk("reset_fwd_data", 48'(bus.fwd_data), 48'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b0, Gap);

    for (int v = 0; v < 6; v++) begin
      v_valid = n_valid; v_err = n_err; v_fe = n_fe; v_fe_err = n_fe_err;
`ifdef WS2812_RZ_DECODE_FWD_EN
      exp_w = vecs[v].exp_words_fwd;
`else
      exp_w = vecs[v].exp_words_mon;
`endif
      fwd_ones0 = fwd_ones;
      for (int i = 0; i < vecs[v].nbits; i++) begin
        if (i == 24) fwd_win = 1'b1;
        if (i == 23 || (i == 47 && exp_w == 2)) begin
          model_rgb = (i == 23) ? vecs[v].data[47:24] : vecs[v].data[23:0];
          exp_q.push_back(model_rgb);
        end
        send_bit(vecs[v].data[47-i]);
        if (i == vecs[v].glitch_at) begin
          hold(1'b1, 2);
          hold(1'b0, 20);
        end
      end
      hold(1'b0, Gap);
      fwd_win = 1'b0;
      chk($sformatf("v%0d_words", v), 48'(n_valid - v_valid), 48'(exp_w));
      chk($sformatf("v%0d_pending", v), 48'(exp_q.size()), 48'h0);
      chk($sformatf("v%0d_rx_err", v), 48'(n_err - v_err), 48'(vecs[v].exp_err));
      chk($sformatf("v%0d_frame_end", v), 48'(n_fe - v_fe), 48'(vecs[v].exp_fe));
      chk($sformatf("v%0d_fe_with_err", v), 48'(n_fe_err - v_fe_err), 48'(vecs[v].exp_fe_err));
      chk($sformatf("v%0d_rgb_hold", v), 48'(bus.RGB), 48'(model_rgb));
      if (v == 0) chk("fe_delay", 48'(fe_cyc - last_valid_cyc), 48'(ResetLow + 1));
`ifdef WS2812_RZ_DECODE_FWD_EN
      if (v == 1) begin
        chk("fwd_match", 48'(fwd_bad), 48'h0);
        chk("fwd_active", 48'(fwd_ones - fwd_ones0 > 0), 48'h1);
      end
`endif
    end

    // Stuck high: error when high_cnt reaches 56, then symbols ignored until a reset gap.
    v_valid = n_valid; v_err = n_err; v_fe = n_fe;
    n0 = cyc;
    hold(1'b1, 60);
    hold(1'b0, 20);
    send_bits(48'hA5C33C_000000, 0, 24);
    hold(1'b0, Gap);
    chk("stuck_rx_err", 48'(n_err - v_err), 48'h1);
    chk("stuck_err_cycle", 48'(err_cyc - n0), 48'(3 + HighMaxDflt));
    chk("stuck_no_words", 48'(n_valid - v_valid), 48'h0);
    chk("stuck_no_frame_end", 48'(n_fe - v_fe), 48'h0);
    model_rgb = 24'h5AA55A;
    exp_q.push_back(model_rgb);
    send_bits(48'h5AA55A_000000, 0, 24);
    hold(1'b0, Gap);
    chk("after_stuck_pending", 48'(exp_q.size()), 48'h0);

    // Reset mid-word: word discarded, outputs cleared, SYNC gap required again.
    send_bits(48'hC0FFEE_000000, 0, 12);
    bus.RZ_data = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreset_rgb", 48'(bus.RGB), 48'h0);
    chk("midreset_rx_err", 48'(bus.rx_err), 48'h0);
    model_rgb = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b0, 20);
    v_valid = n_valid; v_err = n_err; v_fe = n_fe;
    send_bits(48'hC0FFEE_000000, 12, 12);
    hold(1'b0, Gap);
    chk("midreset_no_words", 48'(n_valid - v_valid), 48'h0);
    chk("midreset_no_frame_end", 48'(n_fe - v_fe), 48'h0);
    chk("midreset_no_err", 48'(n_err - v_err), 48'h0);
    model_rgb = 24'h3C5A96;
    exp_q.push_back(model_rgb);
    send_bits(48'h3C5A96_000000, 0, 24);
    hold(1'b0, Gap);
    chk("midreset_recover_pending", 48'(exp_q.size()), 48'h0);
    chk("final_rgb", 48'(bus.RGB), 48'(model_rgb));
`ifndef WS2812_RZ_DECODE_FWD_EN
    chk("monitor_fwd_low", 48'(fwd_high), 48'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
